frame_sequencer: RTL and testbench

//  Frame-level controller for the lane-detection top level. It sequences each frame through

---
 rtl/frame_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Frame-level controller for the lane-detection top level. Each frame walks
// through LOAD -> PROCESS (edge/hough) -> DRAW (line highlight) -> READOUT
// (host stream) -> DONE, then returns to IDLE.
//
// The block owns both image BRAM ports:
//   * write port: multiplexed by phase. The loader owns it in LOAD and the
//     highlighter owns it in DRAW. Any write strobe arriving in the wrong
//     phase is refused and counted in a saturating 16-bit counter.
//   * read port: driven by a small prefetcher that streams the whole image in
//     raster order into a 2-entry skid buffer. The host drains that buffer
//     with ready/valid handshaking.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   frame_start           pulse, starts a frame (only looked at in IDLE)
//   load_wr_*             image_loader write strobe / address / data
//   load_finished         loader has written every pixel
//   hough_done            hough produced rho/theta
//   hl_wr_*               highlight write strobe / address / data
//   finish_draw_a_line    highlight finished drawing
//   start_draw            1-cycle pulse to highlight, first DRAW cycle
//   bram_wr_*             gated image BRAM write port
//   bram_rd_addr          image BRAM read address (data returns 1 cycle later)
//   bram_rd_data          image BRAM read data
//   out_valid/out_ready   host readout handshake, out_data = raster pixel
//   busy                  frame in progress (state != IDLE)
//   frame_done            1-cycle pulse after the last pixel is accepted
//   dropped_writes        saturating count of refused write strobes
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int IMAGE_SIZE = WIDTH * HEIGHT,
    parameter int DATA_WIDTH = 24,
    // Derived; leave at the default.
    parameter int AW         = $clog2(IMAGE_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  load_wr_en,
    input  logic [AW-1:0]         load_wr_addr,
    input  logic [DATA_WIDTH-1:0] load_wr_data,
    input  logic                  load_finished,
    input  logic                  hough_done,
    input  logic                  hl_wr_en,
    input  logic [AW-1:0]         hl_wr_addr,
    input  logic [DATA_WIDTH-1:0] hl_wr_data,
    input  logic                  finish_draw_a_line,
    output logic                  start_draw,
    output logic                  bram_wr_en,
    output logic [AW-1:0]         bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic [AW-1:0]         bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           dropped_writes
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_PROCESS = 3'd2;
    localparam logic [2:0] S_DRAW    = 3'd3;
    localparam logic [2:0] S_READOUT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Pixel counters need one extra bit so they can hold IMAGE_SIZE itself.
    localparam logic [AW:0] PIX_TOTAL = (AW+1)'(IMAGE_SIZE);
    localparam logic [AW:0] PIX_LAST  = (AW+1)'(IMAGE_SIZE - 1);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

    localparam int SLOTS = 2;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]      state_reg;
    logic [2:0]      state_next;
    logic            start_draw_reg;
    logic [15:0]     dropped_reg;
    logic [15:0]     dropped_next;

    logic [AW:0]     rd_cnt_reg;      // reads issued this frame
    logic [AW:0]     pop_cnt_reg;     // pixels accepted by the host
    logic [AW-1:0]   rd_addr_reg;     // last issued read address
    logic            in_flight_reg;   // a read was issued last cycle
    logic [1:0]      buf_cnt_reg;     // skid buffer occupancy, 0..2
    logic [1:0]      buf_cnt_next;
    logic            buf_wr_ptr_reg;
    logic            buf_rd_ptr_reg;

    // -------------------------------------------------------------------------
    // Phase decode
    // -------------------------------------------------------------------------
    logic in_load;
    logic in_draw;
    logic in_readout;
    logic readout_start;

    assign in_load       = (state_reg == S_LOAD);
    assign in_draw       = (state_reg == S_DRAW);
    assign in_readout    = (state_reg == S_READOUT);
    assign readout_start = in_draw && finish_draw_a_line;

    // -------------------------------------------------------------------------
    // Write-port gating (combinational, zero latency)
    // -------------------------------------------------------------------------
    always_comb begin
        bram_wr_en   = 1'b0;
        bram_wr_addr = '0;
        bram_wr_data = '0;
        if (in_load) begin
            bram_wr_en   = load_wr_en;
            bram_wr_addr = load_wr_addr;
            bram_wr_data = load_wr_data;
        end else if (in_draw) begin
            bram_wr_en   = hl_wr_en;
            bram_wr_addr = hl_wr_addr;
            bram_wr_data = hl_wr_data;
        end
    end

    // Refused strobes: both sources can be refused in the same cycle, so the
    // increment is 0..2 and the add is done one bit wider to detect overflow.
    logic        refused_load;
    logic        refused_hl;
    logic [1:0]  drop_inc;
    logic [16:0] dropped_sum;

    assign refused_load = load_wr_en && !in_load;
    assign refused_hl   = hl_wr_en && !in_draw;
    assign drop_inc     = {1'b0, refused_load} + {1'b0, refused_hl};
    assign dropped_sum  = {1'b0, dropped_reg} + {15'd0, drop_inc};
    assign dropped_next = dropped_sum[16] ? 16'hFFFF : dropped_sum[15:0];

    // -------------------------------------------------------------------------
    // Readout prefetcher
    // -------------------------------------------------------------------------
    logic       pop;
    logic       capture;
    logic       issue;
    logic [2:0] occupancy;

    assign out_valid = (buf_cnt_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    assign capture   = in_flight_reg;
    assign occupancy = {1'b0, buf_cnt_reg} + {2'b00, in_flight_reg};

    // A read may issue while buffered + in-flight words leave room for it.
    // A pop in this same cycle frees a slot before the read data lands, so it
    // is credited here; without that credit the stream stalls every third
    // cycle instead of sustaining one pixel per cycle.
    assign issue = in_readout && (rd_cnt_reg < PIX_TOTAL) &&
                   ((occupancy < 3'd2) || pop);

    // The address follows the counter on an issuing cycle and otherwise holds
    // the last address used; outside READOUT it is parked at zero.
    always_comb begin
        bram_rd_addr = '0;
        if (in_readout) begin
            bram_rd_addr = issue ? rd_cnt_reg[AW-1:0] : rd_addr_reg;
        end
    end

    always_comb begin
        buf_cnt_next = buf_cnt_reg;
        case ({capture, pop})
            2'b10:   buf_cnt_next = buf_cnt_reg + 2'd1;
            2'b01:   buf_cnt_next = buf_cnt_reg - 2'd1;
            default: buf_cnt_next = buf_cnt_reg;
        endcase
    end

    // -------------------------------------------------------------------------
    // Skid buffer storage: one register per slot, written round-robin.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] slot_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (capture && (buf_wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= bram_rd_data;
                end
            end
        end
    endgenerate

    assign out_data = buf_rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (frame_start)   state_next = S_LOAD;
            S_LOAD:    if (load_finished) state_next = S_PROCESS;
            S_PROCESS: if (hough_done)    state_next = S_DRAW;
            S_DRAW:    if (finish_draw_a_line) state_next = S_READOUT;
            S_READOUT: if (pop && (pop_cnt_reg == PIX_LAST)) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            start_draw_reg <= 1'b0;
            dropped_reg    <= 16'd0;
            rd_cnt_reg     <= '0;
            pop_cnt_reg    <= '0;
            rd_addr_reg    <= '0;
            in_flight_reg  <= 1'b0;
            buf_cnt_reg    <= 2'd0;
            buf_wr_ptr_reg <= 1'b0;
            buf_rd_ptr_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            // Registered so it lands exactly in the first DRAW cycle.
            start_draw_reg <= (state_reg == S_PROCESS) && hough_done;
            dropped_reg    <= dropped_next;

            if (readout_start) begin
                // Fresh stream for this frame.
                rd_cnt_reg     <= '0;
                pop_cnt_reg    <= '0;
                rd_addr_reg    <= '0;
                in_flight_reg  <= 1'b0;
                buf_cnt_reg    <= 2'd0;
                buf_wr_ptr_reg <= 1'b0;
                buf_rd_ptr_reg <= 1'b0;
            end else begin
                in_flight_reg <= issue;
                if (issue) begin
                    rd_cnt_reg  <= rd_cnt_reg + CNT_ONE;
                    rd_addr_reg <= rd_cnt_reg[AW-1:0];
                end
                if (pop) begin
                    pop_cnt_reg    <= pop_cnt_reg + CNT_ONE;
                    buf_rd_ptr_reg <= ~buf_rd_ptr_reg;
                end
                if (capture) begin
                    buf_wr_ptr_reg <= ~buf_wr_ptr_reg;
                end
                buf_cnt_reg <= buf_cnt_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign start_draw     = start_draw_reg;
    assign busy           = (state_reg != S_IDLE);
    assign frame_done     = (state_reg == S_DONE);
    assign dropped_writes = dropped_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Drives whole frames through frame_sequencer against a behavioural image BRAM.
// A phase-level model tracks where the frame should be, what the write port
// must show, the expected refused-strobe count and which pixel the host should
// see next; a negedge compare process checks the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);
    localparam int DW = 24;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_PROC = 2;
    localparam int P_DRAW = 3;
    localparam int P_READ = 4;
    localparam int P_DONE = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          load_wr_en;
    logic [AW-1:0] load_wr_addr;
    logic [DW-1:0] load_wr_data;
    logic          load_finished;
    logic          hough_done;
    logic          hl_wr_en;
    logic [AW-1:0] hl_wr_addr;
    logic [DW-1:0] hl_wr_data;
    logic          finish_draw_a_line;
    logic          start_draw;
    logic          bram_wr_en;
    logic [AW-1:0] bram_wr_addr;
    logic [DW-1:0] bram_wr_data;
    logic [AW-1:0] bram_rd_addr;
    logic [DW-1:0] bram_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          frame_done;
    logic [15:0]   dropped_writes;

    always #5 clock = ~clock;

    frame_sequencer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_WIDTH (DW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .frame_start        (frame_start),
        .load_wr_en         (load_wr_en),
        .load_wr_addr       (load_wr_addr),
        .load_wr_data       (load_wr_data),
        .load_finished      (load_finished),
        .hough_done         (hough_done),
        .hl_wr_en           (hl_wr_en),
        .hl_wr_addr         (hl_wr_addr),
        .hl_wr_data         (hl_wr_data),
        .finish_draw_a_line (finish_draw_a_line),
        .start_draw         (start_draw),
        .bram_wr_en         (bram_wr_en),
        .bram_wr_addr       (bram_wr_addr),
        .bram_wr_data       (bram_wr_data),
        .bram_rd_addr       (bram_rd_addr),
        .bram_rd_data       (bram_rd_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .busy               (busy),
        .frame_done         (frame_done),
        .dropped_writes     (dropped_writes)
    );

    // Image BRAM with registered read.
    logic [DW-1:0] mem [N];
    always @(posedge clock) begin
        if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
        bram_rd_data <= mem[bram_rd_addr];
    end

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [DW-1:0] exp_img [N];   // what the image must hold
    int  m_phase     = P_IDLE;
    int  m_dropped   = 0;
    int  m_acc       = 0;         // pixels accepted so far this frame
    bit  m_start     = 1'b0;
    bit  checking_on = 1'b0;
    bit  hs          = 1'b0;      // handshake seen at the preceding negedge
    int  fd_count    = 0;
    int  sd_count    = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase     = P_IDLE;
            m_dropped   = 0;
            m_acc       = 0;
            m_start     = 1'b0;
            checking_on = 1'b1;
        end else begin
            int d;
            d = 0;
            if (load_wr_en && m_phase != P_LOAD) d++;
            if (hl_wr_en && m_phase != P_DRAW) d++;
            m_dropped = (m_dropped + d > 65535) ? 65535 : m_dropped + d;
            m_start   = (m_phase == P_PROC) && hough_done;
            case (m_phase)
                P_IDLE: if (frame_start) m_phase = P_LOAD;
                P_LOAD: if (load_finished) m_phase = P_PROC;
                P_PROC: if (hough_done) m_phase = P_DRAW;
                P_DRAW: if (finish_draw_a_line) begin
                            m_phase = P_READ;
                            m_acc   = 0;
                        end
                P_READ: if (hs) begin
                            m_acc++;
                            if (m_acc == N) m_phase = P_DONE;
                        end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle compare process
    // -------------------------------------------------------------------------
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clock) begin
        logic exp_en;
        hs = out_valid && out_ready;
        if (checking_on) begin
            chk("busy", busy, m_phase != P_IDLE);
            chk("frame_done", frame_done, m_phase == P_DONE);
            chk("start_draw", start_draw, m_start);
            chk("dropped_writes", dropped_writes, m_dropped);
            exp_en = (m_phase == P_LOAD) ? load_wr_en :
                     (m_phase == P_DRAW) ? hl_wr_en : 1'b0;
            chk("bram_wr_en", bram_wr_en, exp_en);
            if (exp_en) begin
                chk("bram_wr_addr", bram_wr_addr,
                    (m_phase == P_LOAD) ? load_wr_addr : hl_wr_addr);
                chk("bram_wr_data", bram_wr_data,
                    (m_phase == P_LOAD) ? load_wr_data : hl_wr_data);
            end
            if (m_phase != P_READ) begin
                chk("out_valid_idle", out_valid, 1'b0);
                chk("bram_rd_addr_idle", bram_rd_addr, 0);
            end
            if (out_valid) begin
                if (m_acc < N) chk("out_data", out_data, exp_img[m_acc]);
                else fail_now("extra_pixel", m_acc, N - 1);
            end
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1'b1);
                chk("stall_data_held", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready && !reset;
            prev_data  = out_data;
            if (frame_done) fd_count++;
            if (start_draw) sd_count++;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        frame_start        = 1'b0;
        load_wr_en         = 1'b0;
        load_wr_addr       = '0;
        load_wr_data       = '0;
        load_finished      = 1'b0;
        hough_done         = 1'b0;
        hl_wr_en           = 1'b0;
        hl_wr_addr         = '0;
        hl_wr_data         = '0;
        finish_draw_a_line = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clock);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_dropped"}, dropped_writes, 0);
        chk({tag, "_start_draw"}, start_draw, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_rd_addr"}, bram_rd_addr, 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        out_ready = 1'b0;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    // ready_mode 1: out_ready held high; 2: random (~30% low)
    // abort 0: none; 1: reset mid-DRAW; 2: reset mid-READOUT
    task automatic run_frame(input int ready_mode, input int abort, input bit extras);
        int c;
        fd_count = 0;
        sd_count = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            load_wr_en   = 1'b1;
            load_wr_addr = AW'(i);
            load_wr_data = DW'($urandom);
            exp_img[i]   = load_wr_data;
            hl_wr_en     = extras && (i == 3 || i == 7 || i == 11);
            hl_wr_addr   = AW'(i);
            hl_wr_data   = 24'h123456;
            hough_done   = extras && (i == 20);   // outside PROCESS: ignored
            tick();
        end
        clear_inputs();
        load_finished = 1'b1;
        tick();
        load_finished = 1'b0;
        if (extras) begin
            // Loader write, frame_start and finish_draw_a_line in PROCESS.
            load_wr_en         = 1'b1;
            load_wr_addr       = AW'(5);
            load_wr_data       = 24'hABCDEF;
            frame_start        = 1'b1;
            finish_draw_a_line = 1'b1;
            tick();
            clear_inputs();
            @(negedge clock);
            chk("dropped_after_gating", dropped_writes, 16'd4);
            chk("busy_in_process", busy, 1'b1);
        end
        repeat ($urandom_range(0, 3)) tick();
        hough_done = 1'b1;
        tick();
        hough_done = 1'b0;
        // First DRAW cycle: highlight pixel 100, plus a refused loader strobe.
        hl_wr_en      = 1'b1;
        hl_wr_addr    = AW'(100);
        hl_wr_data    = 24'hFF0000;
        exp_img[100]  = 24'hFF0000;
        load_wr_en    = extras;
        load_wr_addr  = AW'(100);
        load_wr_data  = 24'h00FF00;
        @(negedge clock);
        chk("start_draw_first_cycle", start_draw, 1'b1);
        tick();
        load_wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hl_wr_addr = AW'($urandom_range(0, N - 1));
            if (hl_wr_addr == AW'(100)) hl_wr_addr = AW'(0);
            hl_wr_data = DW'($urandom);
            exp_img[hl_wr_addr] = hl_wr_data;
            tick();
        end
        hl_wr_en = 1'b0;
        if (abort == 1) begin
            do_reset();
            check_reset_state("abort_draw");
            tick();
            return;
        end
        finish_draw_a_line = 1'b1;
        tick();
        finish_draw_a_line = 1'b0;
        c = 0;
        while (m_phase != P_IDLE && c < 10 * N + 20) begin
            out_ready = (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 99) >= 30);
            if (abort == 2 && c == N / 2) break;
            @(negedge clock);
            if (ready_mode == 1 && c <= N + 2)
                chk($sformatf("lead_valid_c%0d", c), out_valid, (c >= 2 && c <= N + 1));
            tick();
            c++;
        end
        if (abort == 2) begin
            do_reset();
            check_reset_state("abort_readout");
            tick();
            return;
        end
        out_ready = 1'b0;
        if (c >= 10 * N + 20) fail_now("readout_timeout", c, N + 3);
        chk("pixels_accepted", m_acc, N);
        chk("frame_done_pulses", fd_count, 1);
        chk("start_draw_pulses", sd_count, 1);
        @(negedge clock);
        chk("idle_after_frame", busy, 1'b0);
        chk("bram_px100", mem[100], 24'hFF0000);
        chk("bram_px5_kept", mem[5], exp_img[5]);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        clear_inputs();
        repeat (3) tick();
        reset = 1'b0;
        check_reset_state("after_reset");
        tick();

        run_frame(1, 0, 1'b1);   // gating, highlight, full-rate readout
        run_frame(2, 0, 1'b0);   // backpressured readout
        run_frame(2, 1, 1'b0);   // reset during DRAW
        run_frame(2, 0, 1'b0);   // clean frame after abort
        run_frame(1, 2, 1'b0);   // reset during READOUT
        run_frame(2, 0, 1'b0);   // clean frame after abort

        // Saturation: two refused strobes per IDLE cycle.
        do_reset();
        load_wr_en = 1'b1;
        hl_wr_en   = 1'b1;
        repeat (32767) tick();
        @(negedge clock);
        chk("dropped_65534", dropped_writes, 16'hFFFE);
        tick();
        hl_wr_en = 1'b0;
        @(negedge clock);
        chk("dropped_sat_plus2", dropped_writes, 16'hFFFF);
        tick();
        load_wr_en = 1'b0;
        @(negedge clock);
        chk("dropped_sat_hold", dropped_writes, 16'hFFFF);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
